// File: rtl/uart_tx_fifo_if.sv
// Byte push channel into the UART transmit FIFO.
// The producer drives data/valid; the FIFO answers with ready (= not full).
interface uart_tx_fifo_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter: a small byte FIFO drained LSB-first onto tx
// by a baud-divided FSM running on the system clock.
module uart_tx_fifo #(
    parameter int unsigned CLK_DIV   = 104,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned STOP_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_tx_fifo_if.slave            push,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;

    logic empty, full, push_en, pop_en, baud_end;

    assign empty    = (wp_q == rp_q);
    assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    // A push is refused whenever full, even if the FSM pops in the same cycle.
    assign push_en  = push.valid && !full;
    assign pop_en   = (state_q == StIdle) && !empty;
    assign baud_end = (baud_q == BW'(CLK_DIV - 1));

    always_comb begin
        wp_d    = wp_q + PW'(push_en);
        rp_d    = rp_q + PW'(pop_en);
        ovf_d   = ovf_q | (push.valid & full);
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;

        unique case (state_q)
            StIdle: begin
                if (pop_en) begin
                    shreg_d = mem_q[rp_q[AW-1:0]];
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            StStop: begin
                // bit_q counts stop bits here so the baud counter stays CLK_DIV wide.
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
        endcase

        // Line level follows the current state, so tx lags the state by one cycle.
        unique case (state_q)
            StStart:        tx_d = 1'b0;
            StData:         tx_d = shreg_q[0];
            StIdle, StStop: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wp_q[AW-1:0]] <= push.data;
        end
    end

    assign push.ready = !full;
    assign tx         = tx_q;
    assign busy       = (state_q != StIdle) || !empty;
    assign count      = wp_q - rp_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table vectors, hand sequences for the
// frame/reset corners, and random traffic against a queue-based line model.
module tb_uart_tx_fifo;

    localparam int CD    = 4;
    localparam int DEP   = 4;
    localparam int SB    = 2;
    localparam int FLEN  = (9 + SB) * CD;
    localparam int CD2   = 104;
    localparam int FLEN2 = 10 * CD2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx, busy, overflow;
    logic [2:0] count;
    logic       tx2, busy2, overflow2;
    logic [2:0] count2;

    uart_tx_fifo_if bus ();
    uart_tx_fifo_if bus2 ();

    uart_tx_fifo #(.CLK_DIV(CD), .DEPTH(DEP), .STOP_BITS(SB)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .push     (bus),
        .tx       (tx),
        .busy     (busy),
        .count    (count),
        .overflow (overflow)
    );

    uart_tx_fifo #(.CLK_DIV(CD2), .DEPTH(DEP), .STOP_BITS(1)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .push     (bus2),
        .tx       (tx2),
        .busy     (busy2),
        .count    (count2),
        .overflow (overflow2)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Line level at frame cycle pos (0 = first cycle of the start bit).
    function automatic logic frame_bit(input logic [7:0] b, input int pos, input int cd);
        int i;
        i = pos / cd;
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    // Reference model: queued bytes, byte on the line, cycles since it was popped.
    logic [7:0] m_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] cur;
    int         since_pop;
    logic       m_ovf;

    task automatic model_reset();
        m_q.delete();
        sent_q.delete();
        cur       = '0;
        since_pop = 100000;
        m_ovf     = 1'b0;
    endtask

    function automatic logic model_tx();
        if (since_pop >= 1 && since_pop <= FLEN) return frame_bit(cur, since_pop - 1, CD);
        return 1'b1;
    endfunction

    task automatic step(input logic v, input logic [7:0] d);
        int pre;
        bus.valid = v;
        bus.data  = d;
        @(posedge clk);
        pre = m_q.size();
        if (since_pop >= FLEN && pre > 0) begin
            cur = m_q.pop_front();
            sent_q.push_back(cur);
            since_pop = 0;
        end else if (since_pop < 100000) begin
            since_pop++;
        end
        if (v) begin
            if (pre < DEP) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
        #1;
        chk("m_tx", tx, model_tx());
        chk("m_busy", busy, (since_pop < FLEN) || (m_q.size() > 0));
        chk("m_ready", bus.ready, m_q.size() < DEP);
        chk("m_count", count, m_q.size());
        chk("m_overflow", overflow, m_ovf);
    endtask

    // Independent line decoder on the main DUT, sampling mid-bit on negedge.
    logic [7:0] rx_q[$];
    logic [7:0] mon_sh;
    int         mon_cnt;

    always @(negedge clk) begin
        if (!rst) begin
            mon_cnt <= -1;
        end else if (mon_cnt < 0) begin
            if (!tx) mon_cnt <= 1;
        end else begin
            if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2) mon_sh <= {tx, mon_sh[7:1]};
            if (mon_cnt == 38) begin
                rx_q.push_back(mon_sh);
                mon_cnt <= -1;
            end else begin
                mon_cnt <= mon_cnt + 1;
            end
        end
    end

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       exp_ready;
        logic [2:0] exp_count;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [10:0] seq;

        vecs[0] = '{1'b1, 8'h61, 1'b1, 3'd1, 1'b0};
        vecs[1] = '{1'b1, 8'h62, 1'b1, 3'd1, 1'b0};
        vecs[2] = '{1'b1, 8'h63, 1'b1, 3'd2, 1'b0};
        vecs[3] = '{1'b1, 8'h64, 1'b1, 3'd3, 1'b0};
        vecs[4] = '{1'b1, 8'h65, 1'b0, 3'd4, 1'b0};
        vecs[5] = '{1'b1, 8'h66, 1'b0, 3'd4, 1'b1};
        vecs[6] = '{1'b1, 8'h66, 1'b0, 3'd4, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1};

        bus.valid  = 1'b0;
        bus.data   = '0;
        bus2.valid = 1'b0;
        bus2.data  = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_tx2", tx2, 1'b1);
        chk("rst_count2", count2, 3'd0);
        rst = 1'b1;

        // Idle line after reset
        repeat (200) step(1'b0, 8'h00);
        chk("idle_tx", tx, 1'b1);
        chk("idle_busy", busy, 1'b0);

        // Single 'A': tx falls two cycles after the push, 4 cycles per bit
        seq = 11'b110_1000_0010;
        step(1'b1, 8'h41);
        chk("a_count", count, 3'd1);
        step(1'b0, 8'h00);
        chk("a_pop_tx", tx, 1'b1);
        for (int k = 0; k < FLEN; k++) begin
            step(1'b0, 8'h00);
            chk("a_bit", tx, seq[k/CD]);
        end
        chk("a_busy_end", busy, 1'b0);
        repeat (4) step(1'b0, 8'h00);
        chk("a_rx_n", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("a_rx", rx_q[0], 8'h41);
        rx_q.delete();

        // Burst 'a'..'e', then hold valid while full
        foreach (vecs[i]) begin
            step(vecs[i].valid, vecs[i].data);
            chk("tbl_ready", bus.ready, vecs[i].exp_ready);
            chk("tbl_count", count, vecs[i].exp_count);
            chk("tbl_ovf", overflow, vecs[i].exp_ovf);
            chk("tbl_busy", busy, 1'b1);
        end
        for (int k = 0; k < 5 * (FLEN + 1) + 10; k++) begin
            step(1'b0, 8'h00);
            if (count > 3'd4) chk("burst_count_max", count, 3'd4);
        end
        chk("burst_ovf_sticky", overflow, 1'b1);
        chk("burst_rx_n", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("burst_rx", rx_q[i], 8'h61 + i);

        // Reset during data bit 3 of 8'h55
        step(1'b1, 8'h55);
        repeat (19) step(1'b0, 8'h00);
        chk("r5_pre_tx", tx, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk("r5_tx", tx, 1'b1);
        chk("r5_count", count, 3'd0);
        chk("r5_busy", busy, 1'b0);
        chk("r5_ovf", overflow, 1'b0);
        model_reset();
        rx_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 60; k++) step(1'b0, 8'h00);
        chk("r5_idle_tx", tx, 1'b1);
        chk("r5_rx_none", rx_q.size(), 0);

        // Random traffic: alternating sparse and dense phases
        for (int i = 0; i < 1500; i++) begin
            int p;
            p = ((i / 300) % 2 == 1) ? 60 : 8;
            step($urandom_range(99) < p, 8'($urandom));
        end
        for (int k = 0; k < (DEP + 1) * (FLEN + 1) + 10; k++) step(1'b0, 8'h00);
        chk("rnd_rx_n", rx_q.size(), sent_q.size());
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++) chk("rnd_rx", rx_q[i], sent_q[i]);

        // One stop bit, 104 clocks per bit: 1041-cycle frame incl. pop cycle
        bus2.data  = 8'h44;
        bus2.valid = 1'b1;
        step(1'b0, 8'h00);
        bus2.valid = 1'b0;
        chk("d6_count", count2, 3'd1);
        for (int k = 1; k <= FLEN2 + 1; k++) begin
            step(1'b0, 8'h00);
            chk("d6_tx", tx2, (k >= 2) ? frame_bit(8'h44, k - 2, CD2) : 1'b1);
            if (k >= FLEN2) chk("d6_busy", busy2, k < FLEN2 + 1);
        end
        chk("d6_ovf", overflow2, 1'b0);
        chk("d6_count_end", count2, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
